// File: rtl/id_regfile_scoreboard.sv
// ID-stage register file with a per-register pending-write scoreboard.
// WB feeds the single write port. Decode reads rs/rt combinationally and stalls on
// outstanding writers.
// Optional macro WB_BYPASS_EN forwards the WB result to the read ports in the same cycle
// and hides busy for a lone writer that is retiring now.
module id_regfile_scoreboard #(
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned CNT_W = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    input  logic [AW-1:0] rs_addr,
    input  logic [AW-1:0] rt_addr,
    output logic [DW-1:0] rs_data,
    output logic [DW-1:0] rt_data,
    input  logic          issue_we,
    input  logic [AW-1:0] issue_addr,
    output logic          rs_busy,
    output logic          rt_busy,
    output logic          stall,
    output logic          sb_full,
    output logic          sb_err
);

    localparam int unsigned Depth = 2 ** AW;
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [DW-1:0]    gpr_q [Depth];
    logic [CNT_W-1:0] cnt_q [Depth];
    logic [CNT_W-1:0] cnt_d [Depth];
    logic             sb_err_q, sb_err_d;
    logic             wb_valid;
    logic [CNT_W-1:0] rs_cnt, rt_cnt;

    // Writes to r0 are discarded everywhere.
    assign wb_valid = wb_we && (wb_addr != '0);

    // GPR array: one WB write port, r0 stays at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < Depth; i++) begin
                gpr_q[i] <= '0;
            end
        end else if (wb_valid) begin
            gpr_q[wb_addr] <= wb_data;
        end
    end

    // Full-scoreboard detection for the register being issued.
    always_comb begin
        sb_full = (issue_addr != '0) && (cnt_q[issue_addr] == CntMax);
    end

    // Per-register pending count: same-edge issue and retire to one register cancel out.
    always_comb begin
        for (int r = 0; r < Depth; r++) begin
            cnt_d[r] = cnt_q[r];
        end
        for (int r = 1; r < Depth; r++) begin
            logic inc, dec;
            inc = issue_we && (issue_addr == AW'(r)) && !sb_full;
            dec = wb_we && (wb_addr == AW'(r)) && (cnt_q[r] != '0);
            if (inc && !dec) begin
                cnt_d[r] = cnt_q[r] + CNT_W'(1);
            end else if (dec && !inc) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
        end
        cnt_d[0] = '0;
    end

    // Sticky flag for a WB write nobody was waiting for.
    always_comb begin
        sb_err_d = sb_err_q || (wb_valid && (cnt_q[wb_addr] == '0));
    end

    // Scoreboard and error state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < Depth; i++) begin
                cnt_q[i] <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < Depth; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            sb_err_q <= sb_err_d;
        end
    end

    assign rs_cnt = cnt_q[rs_addr];
    assign rt_cnt = cnt_q[rt_addr];

    // Read ports and busy flags.
    always_comb begin
        rs_data = (rs_addr == '0) ? '0 : gpr_q[rs_addr];
        rt_data = (rt_addr == '0) ? '0 : gpr_q[rt_addr];
        rs_busy = (rs_cnt != '0);
        rt_busy = (rt_cnt != '0);
`ifdef WB_BYPASS_EN
        if (wb_valid && (rs_addr == wb_addr)) begin
            rs_data = wb_data;
            // A single outstanding writer retiring this cycle no longer blocks decode.
            if (rs_cnt == CNT_W'(1)) begin
                rs_busy = 1'b0;
            end
        end
        if (wb_valid && (rt_addr == wb_addr)) begin
            rt_data = wb_data;
            if (rt_cnt == CNT_W'(1)) begin
                rt_busy = 1'b0;
            end
        end
`endif
        stall = rs_busy || rt_busy || sb_full;
    end

    assign sb_err = sb_err_q;

endmodule

// File: tb/tb_id_regfile_scoreboard.sv
// Self-checking bench: a behavioural register-file/scoreboard model checked every cycle,
// plus directed vectors with literal expectations.
module tb_id_regfile_scoreboard;

    localparam int MaxCnt = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic [4:0]  rs_addr = '0;
    logic [4:0]  rt_addr = '0;
    logic [31:0] rs_data, rt_data;
    logic        issue_we = 1'b0;
    logic [4:0]  issue_addr = '0;
    logic        rs_busy, rt_busy, stall, sb_full, sb_err;

    int n_checks = 0;
    int n_pass   = 0;

    id_regfile_scoreboard dut (
        .clk        (clk),
        .reset      (reset),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .issue_we   (issue_we),
        .issue_addr (issue_addr),
        .rs_busy    (rs_busy),
        .rt_busy    (rt_busy),
        .stall      (stall),
        .sb_full    (sb_full),
        .sb_err     (sb_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Model state: register contents, number of writers still outstanding, error flag.
    logic [31:0] m_gpr [32];
    int          m_cnt [32];
    bit          m_err;

    function automatic bit wb_hits(input logic [4:0] a);
        return wb_we && (wb_addr != 0) && (wb_addr == a);
    endfunction

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (a == 0) return 32'h0;
`ifdef WB_BYPASS_EN
        if (wb_hits(a)) return wb_data;
`endif
        return m_gpr[a];
    endfunction

    function automatic bit exp_busy(input logic [4:0] a);
`ifdef WB_BYPASS_EN
        if (wb_hits(a) && m_cnt[a] == 1) return 1'b0;
`endif
        return m_cnt[a] != 0;
    endfunction

    function automatic bit exp_full();
        return (issue_addr != 0) && (m_cnt[issue_addr] == MaxCnt);
    endfunction

    // Model update on each edge, following the issue/retire rules.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                m_gpr[i] <= 32'h0;
                m_cnt[i] <= 0;
            end
            m_err <= 1'b0;
        end else begin
            bit inc, dec;
            inc = issue_we && (issue_addr != 0) && (m_cnt[issue_addr] < MaxCnt);
            dec = wb_we && (wb_addr != 0) && (m_cnt[wb_addr] > 0);
            if (wb_we && wb_addr != 0) begin
                m_gpr[wb_addr] <= wb_data;
                if (m_cnt[wb_addr] == 0) m_err <= 1'b1;
            end
            if (inc && dec && issue_addr == wb_addr) begin
                // net zero
            end else begin
                if (inc) m_cnt[issue_addr] <= m_cnt[issue_addr] + 1;
                if (dec) m_cnt[wb_addr] <= m_cnt[wb_addr] - 1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        bit rb, tb;
        rb = exp_busy(rs_addr);
        tb = exp_busy(rt_addr);
        check("rs_data", rs_data, exp_data(rs_addr));
        check("rt_data", rt_data, exp_data(rt_addr));
        check("rs_busy", {31'b0, rs_busy}, {31'b0, rb});
        check("rt_busy", {31'b0, rt_busy}, {31'b0, tb});
        check("sb_full", {31'b0, sb_full}, {31'b0, exp_full()});
        check("stall", {31'b0, stall}, {31'b0, rb | tb | exp_full()});
        check("sb_err", {31'b0, sb_err}, {31'b0, m_err});
    end

    // Advance to just after the next edge, apply one cycle of inputs, wait to the sample point.
    task automatic cyc(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb,
                       input logic iw, input logic [4:0] ia);
        @(posedge clk);
        #1;
        wb_we = we; wb_addr = wa; wb_data = wd;
        rs_addr = ra; rt_addr = rb;
        issue_we = iw; issue_addr = ia;
        @(negedge clk);
    endtask

    initial begin
        #2 reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("rst_rs_data", rs_data, 32'h0);
            check("rst_stall", {31'b0, stall}, 32'h0);
        end
        reset = 1'b1;

        // Every address reads zero out of reset.
        for (int i = 0; i < 32; i++) begin
            cyc(0, 0, 0, 5'(i), 5'(31 - i), 0, 0);
            check("init_rd", rs_data, 32'h0);
        end

        // r0 ignores writes and issues.
        cyc(1, 0, 32'hDEADBEEF, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("r0_data", rs_data, 32'h0);
        check("r0_busy", {31'b0, rs_busy}, 32'h0);

        // Basic write/read (issued first so the write is expected).
        cyc(0, 0, 0, 0, 0, 1, 5);
        cyc(1, 5, 32'h12345678, 0, 0, 0, 0);
        cyc(0, 0, 0, 5, 6, 0, 0);
        check("r5_read", rs_data, 32'h12345678);
        check("r6_read", rt_data, 32'h0);

        // Same-cycle read of a register being written.
        cyc(0, 0, 0, 0, 0, 1, 7);
        cyc(1, 7, 32'hA5A5A5A5, 7, 7, 0, 0);
`ifdef WB_BYPASS_EN
        check("byp_same", rs_data, 32'hA5A5A5A5);
        check("byp_busy", {31'b0, rs_busy}, 32'h0);
`else
        check("nobyp_same", rs_data, 32'h0);
        check("nobyp_busy", {31'b0, rs_busy}, 32'h1);
`endif
        cyc(0, 0, 0, 7, 0, 0, 0);
        check("byp_next", rs_data, 32'hA5A5A5A5);

        // Hazard on a single outstanding writer.
        cyc(0, 0, 0, 0, 0, 1, 3);
        cyc(0, 0, 0, 3, 0, 0, 0);
        check("haz_busy", {31'b0, rs_busy}, 32'h1);
        check("haz_stall", {31'b0, stall}, 32'h1);
        cyc(1, 3, 32'h00000033, 3, 0, 0, 0);
`ifdef WB_BYPASS_EN
        check("haz_ret_busy", {31'b0, rs_busy}, 32'h0);
`else
        check("haz_ret_busy", {31'b0, rs_busy}, 32'h1);
`endif
        cyc(0, 0, 0, 3, 0, 0, 0);
        check("haz_clr_busy", {31'b0, rs_busy}, 32'h0);
        check("haz_clr_stall", {31'b0, stall}, 32'h0);

        // Saturation on r9, including a net-zero issue+retire below the limit.
        cyc(0, 0, 0, 0, 0, 1, 9);
        cyc(0, 0, 0, 0, 9, 1, 9);
        check("sat_rt_busy", {31'b0, rt_busy}, 32'h1);
        cyc(1, 9, 32'h99, 0, 0, 1, 9);
        check("sat_nz_full", {31'b0, sb_full}, 32'h0);
        cyc(0, 0, 0, 0, 0, 1, 9);
        check("sat_3rd_full", {31'b0, sb_full}, 32'h0);
        cyc(0, 0, 0, 0, 0, 1, 9);
        check("sat_full", {31'b0, sb_full}, 32'h1);
        check("sat_stall", {31'b0, stall}, 32'h1);
        cyc(0, 0, 0, 9, 0, 1, 9);
        check("sat_hold", {31'b0, sb_full}, 32'h1);
        repeat (3) cyc(1, 9, 32'h9009, 9, 0, 0, 9);
        cyc(0, 0, 0, 9, 0, 0, 9);
        check("sat_drained", {31'b0, rs_busy}, 32'h0);
        check("sat_drained_full", {31'b0, sb_full}, 32'h0);
        check("sat_no_err", {31'b0, sb_err}, 32'h0);

        // Underflow: unexpected write still lands and latches the error.
        cyc(1, 12, 32'hCAFEF00D, 0, 0, 0, 0);
        cyc(0, 0, 0, 12, 0, 0, 0);
        check("uf_data", rs_data, 32'hCAFEF00D);
        check("uf_err", {31'b0, sb_err}, 32'h1);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);
        check("uf_sticky", {31'b0, sb_err}, 32'h1);

        // Reset in the middle of activity clears everything at once.
        cyc(0, 0, 0, 0, 0, 1, 4);
        cyc(0, 0, 0, 4, 5, 0, 0);
        check("pre_rst_busy", {31'b0, rs_busy}, 32'h1);
        reset = 1'b0;
        #1;
        check("mid_rst_rs", rs_data, 32'h0);
        check("mid_rst_rt", rt_data, 32'h0);
        check("mid_rst_busy", {31'b0, rs_busy}, 32'h0);
        check("mid_rst_err", {31'b0, sb_err}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        cyc(0, 0, 0, 4, 5, 0, 0);
        check("post_rst_rt", rt_data, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
